// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first serial-to-parallel receiver that locks on a run of aligned comma symbols.
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       serial,
    output logic [8:0] paralelo,
    output logic       byte_stb,
    output logic       active
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    state_t      state, state_n;
    logic [6:0]  sr;
    logic [7:0]  nb;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [3:0]  commacnt, commacnt_n;
    logic [8:0]  paralelo_n;
    logic        byte_stb_n, active_n;
    logic        is_comma, boundary, lock;
    // only the low seven bits of the shift register are ever needed to form the next byte
    assign nb       = {sr, serial};
    assign is_comma = nb == COMMA;
    assign boundary = bitcnt == 3'd7;
    assign lock     = commacnt + 4'd1 == LOCK_COUNT[3:0];
    always_ff @(posedge clk8f) begin
        if (reset) begin
            state    <= SEARCH;
            sr       <= '0;
            bitcnt   <= '0;
            commacnt <= '0;
            paralelo <= '0;
            byte_stb <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= nb[6:0];
            bitcnt   <= bitcnt_n;
            commacnt <= commacnt_n;
            paralelo <= paralelo_n;
            byte_stb <= byte_stb_n;
            active   <= active_n;
        end
    end
    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt + 3'd1;
        commacnt_n = commacnt;
        case (state)
            SEARCH: begin
                bitcnt_n = 3'd0;
                if (is_comma) begin
                    state_n    = ALIGN;
                    commacnt_n = 4'd1;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (!is_comma) begin
                        state_n    = SEARCH;
                        commacnt_n = 4'd0;
                    end else if (lock) begin
                        state_n = ACTIVE;
                    end else begin
                        commacnt_n = commacnt + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end
    always_comb begin
        byte_stb_n = state == ACTIVE && boundary;
        paralelo_n = byte_stb_n ? {!is_comma, nb} : paralelo;
        active_n   = state_n == ACTIVE;
    end
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed stimulus with a queue-based scoreboard checking every byte strobe.
module tb_serial_paralelo_rx;
    localparam logic [7:0] COMMA = 8'hBC;
    typedef struct {logic [8:0] v; int c;} exp_t;
    logic       clk8f = 1'b0;
    logic       reset = 1'b0;
    logic       serial = 1'b0;
    logic [8:0] paralelo;
    logic       byte_stb, active;
    int         cyc = 0, rst_cyc = 0, checks = 0, errors = 0;
    logic       prev_stb = 1'b0;
    exp_t       q[$];
    exp_t       x;

    serial_paralelo_rx dut (
        .clk8f(clk8f), .reset(reset), .serial(serial),
        .paralelo(paralelo), .byte_stb(byte_stb), .active(active)
    );

    always #5 clk8f = ~clk8f;
    always @(posedge clk8f) cyc <= cyc + 1;

    always @(posedge clk8f) begin
        #1;
        if (byte_stb) begin
            checks++;
            if (prev_stb || !active) begin
                errors++;
                $display("FAIL stb_shape: stb=%0b prev=%0b active=%0b at cycle %0d", byte_stb, prev_stb, active, cyc);
            end
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: paralelo=%h at cycle %0d, none expected", paralelo, cyc);
            end else begin
                x = q.pop_front();
                checks++;
                if (paralelo !== x.v || cyc != x.c) begin
                    errors++;
                    $display("FAIL strobe_word: got %h at cycle %0d, expected %h at cycle %0d", paralelo, cyc, x.v, x.c);
                end
            end
        end
        prev_stb = byte_stb;
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        @(posedge clk8f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input logic [8:0] e);
        if (push) q.push_back('{e, cyc + 8});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_paralelo"}, paralelo, 9'h000);
        chk({tag, "_stb"}, 9'(byte_stb), 9'h0);
        chk({tag, "_active"}, 9'(active), 9'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk8f);
        #1;
        check_reset_outputs("reset");
        @(posedge clk8f);
        #1;
        reset = 1'b0;
        rst_cyc = cyc;
    endtask

    // four commas; the lock edge must land exactly lock_bit edges after reset release
    task automatic lock_run(input int lock_bit);
        logic [7:0] c;
        c = COMMA;
        repeat (3) send_byte(COMMA, 1'b0, 9'h0);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        chk("pre_lock_active", 9'(active), 9'h0);
        send_bit(c[0]);
        chk("lock_active", 9'(active), 9'h1);
        chk("lock_bit", 9'(cyc - rst_cyc), 9'(lock_bit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        lock_run(32);
        send_byte(8'hFF, 1'b1, 9'h1FF);
        send_byte(8'h55, 1'b1, 9'h155);
        send_byte(8'h00, 1'b1, 9'h100);

        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        lock_run(35);
        send_byte(8'hA5, 1'b1, 9'h1A5);

        do_reset();
        repeat (3) send_byte(COMMA, 1'b0, 9'h0);
        chk("abort_pre_active", 9'(active), 9'h0);
        send_byte(8'h55, 1'b0, 9'h0);
        chk("abort_active", 9'(active), 9'h0);
        lock_run(64);
        send_byte(8'h0F, 1'b1, 9'h10F);

        send_byte(8'hFF, 1'b1, 9'h1FF);
        send_byte(COMMA, 1'b1, 9'h0BC);
        send_byte(8'h55, 1'b1, 9'h155);
        chk("hold_paralelo", paralelo, 9'h155);

        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        reset = 1'b1;
        @(posedge clk8f);
        #1;
        check_reset_outputs("midbyte");
        reset = 1'b0;
        rst_cyc = cyc;
        lock_run(32);
        send_byte(8'h3C, 1'b1, 9'h13C);

        do_reset();
        repeat (200) send_bit(1'b0);
        chk("zeros_active", 9'(active), 9'h0);
        chk("zeros_paralelo", paralelo, 9'h000);
        do_reset();
        repeat (200) send_bit(1'b1);
        chk("ones_active", 9'(active), 9'h0);
        chk("ones_paralelo", paralelo, 9'h000);

        repeat (3) @(posedge clk8f);
        #2;
        chk("pending_expected", 9'(q.size()), 9'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Serial-to-parallel receiver for the 8-bit serial link driven by the parallel-serial transmitter. It consumes one bit per `clk8f` cycle, MSB first, and finds byte alignment by searching for the comma/idle symbol (0xBC). After a run of consecutive aligned commas it declares the link active. From then on it emits one 9-bit word `{valid, data}` per received byte, with a one-cycle strobe. It feeds the downstream byte-rate logic.

## Interface

- `COMMA`, 8'hBC, idle/alignment symbol; the transmitter sends it whenever it has no valid data.
- `LOCK_COUNT`, 4, number of consecutive aligned commas required to enter ACTIVE (legal range 2..15).

- `clk8f`  input  1  bit clock, one serial bit per rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk8f`.
- `serial`  input  1  serial data, MSB of each byte first.
- `paralelo`  output  9  bit 8 = valid, bits 7:0 = received byte; registered and held between strobes.
- `byte_stb`  output  1  high for exactly one cycle when `paralelo` is updated.
- `active`  output  1  high once lock is achieved; stays high until `reset`.

## Operation

- Shift register `sr[7:0]` updates every edge: `sr <= {sr[6:0], serial}`. In the rules below, "next byte" `nb = {sr[6:0], serial}`.
- `bitcnt` (3 bits) and `commacnt` (4 bits) are internal counters.
- States: SEARCH, ALIGN, ACTIVE.

- SEARCH
  - Bit-sliding search. If `nb == COMMA`: `bitcnt <= 0`, `commacnt <= 1`, go to ALIGN.
  - Otherwise stay in SEARCH.
- ALIGN
  - `bitcnt` increments each edge and wraps 7 -> 0.
  - On the edge where `bitcnt == 7` (byte boundary):
    - `nb == COMMA` and `commacnt + 1 == LOCK_COUNT`: go to ACTIVE, `active <= 1`. This comma is not emitted on `paralelo`.
    - `nb == COMMA` otherwise: `commacnt` increments and the block stays in ALIGN.
    - `nb != COMMA`: go to SEARCH, `commacnt <= 0`. No re-search is done on this same edge.
- ACTIVE
  - `bitcnt` keeps free-running.
  - On each edge with `bitcnt == 7`: `paralelo <= {(nb != COMMA), nb}` and `byte_stb <= 1`.
  - On all other edges, `byte_stb <= 0`.
  - An idle comma is reported as 9'h0BC (valid = 0). Any other byte is reported as `{1'b1, byte}`.
  - ACTIVE is exited only by `reset`. There is no loss-of-lock detection.
- Reset (takes priority on any edge, including mid-byte or mid-lock):
  - `sr`, `bitcnt`, `commacnt` <= 0; state <= SEARCH.
  - `paralelo` <= 9'h000; `byte_stb` <= 0; `active` <= 0.
  - Lock must be fully reacquired afterwards.
- Because `sr` clears to 0, no comma match can occur until 8 real bits have been shifted in after reset.

## Timing

- Serial bit sampled at edge k. If that bit completes a byte in ACTIVE, `paralelo` and `byte_stb` are valid from edge k until edge k+1.
  - Latency: 1 cycle from the last bit to the output.
- `byte_stb` is asserted once every 8 cycles in ACTIVE, never on two consecutive cycles, and never outside ACTIVE.
- `active` rises on the edge that samples the last bit of the LOCK_COUNT-th comma. The first `byte_stb` follows exactly 8 edges later.
- Fastest lock from reset deassertion: 8·LOCK_COUNT edges (32 with the default), provided the first bit after reset is the MSB of a comma.
- Reset asserted on edge k: all outputs are at reset values from edge k. Input bits on edge k are discarded.

## Test plan

- Reset held for 2 cycles, then 4×0xBC followed by 0xFF, 0x55, 0x00, all MSB first:
  - `active` rises on bit 32.
  - `paralelo` = 0x1FF, 0x155, 0x100 on strobes at bits 40, 48, 56.
- 3 junk bits (101) followed by 4×0xBC, then 0xA5:
  - Lock is achieved despite the misalignment.
  - `active` rises 35 bits after reset; first strobe shows 0x1A5.
- 3×0xBC, then 0x55, then 4×0xBC, then 0x0F:
  - ALIGN aborts at the 0x55 and `active` stays 0 through it.
  - Lock completes after the second comma run; `paralelo` = 0x10F.
- In ACTIVE, send 0xFF, 0xBC, 0x55:
  - `paralelo` = 0x1FF, 0x0BC, 0x155.
  - `byte_stb` pulses exactly 3 times, one cycle each, 8 cycles apart.
- In ACTIVE, assert `reset` on bit 4 of a byte:
  - Next edge: `paralelo` = 0x000, `byte_stb` = 0, `active` = 0.
  - After release, 4×0xBC are needed to relock; no strobe occurs before then.
- All-zero and all-ones streams (200 bits) after reset:
  - `active` stays 0, `byte_stb` never pulses, `paralelo` stays 0x000.
